// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Microprogrammed control unit. Holds the control-store address register
//   (CSAR) and the microinstruction register (MIR). Drives the datapath
//   register addresses, mux selects, ALU operation and memory strobes. It
//   computes the next microaddress from the MIR condition field, the datapath
//   flags, IR[13] and the decoded opcode. It stalls on memory accesses until
//   MemoryAck_In is seen.
//
// Ports
//   MICROSEQ_CLOCK_50              in   system clock, rising edge
//   MICROSEQ_ResetInLow_In         in   asynchronous active-low reset
//   MICROSEQ_CSAddress_OutBus      out  CSAR, address into the control store
//   MICROSEQ_CSWord_InBus          in   control-store word (async ROM)
//   MICROSEQ_DirA/B/C_OutBus       out  MIR A/B/C register address fields
//   MICROSEQ_SelectA/B/C_Out       out  MIR AMUX/BMUX/CMUX bits
//   MICROSEQ_ALUOperation_OutBus   out  MIR ALU field
//   MICROSEQ_RD_Out / WR_Out       out  memory read / write strobes
//   MICROSEQ_RegWrite_Out          out  register-file write enable for C
//   MICROSEQ_Flag*_In              in   datapath N/Z/V/C condition codes
//   MICROSEQ_IR13_In               in   IR bit 13
//   MICROSEQ_DecodeOP_InBus        in   {op[1:0], op3/op2[5:0]}
//   MICROSEQ_MemoryAck_In          in   memory completion
module micro_sequencer #(
   parameter int DATAWIDTH_MIR_DIRECTION = 6,
   parameter int DATAWIDTH_ALU_SELECTION = 4,
   parameter int DATAWIDTH_DECODEROP     = 8,
   parameter int DATAWIDTH_CS_ADDRESS    = 11,
   parameter int DATAWIDTH_CS_WORD       = 41
) (
   input  logic                               MICROSEQ_CLOCK_50,
   input  logic                               MICROSEQ_ResetInLow_In,
   output logic [DATAWIDTH_CS_ADDRESS-1:0]    MICROSEQ_CSAddress_OutBus,
   input  logic [DATAWIDTH_CS_WORD-1:0]       MICROSEQ_CSWord_InBus,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] MICROSEQ_DirA_OutBus,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] MICROSEQ_DirB_OutBus,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] MICROSEQ_DirC_OutBus,
   output logic                               MICROSEQ_SelectA_Out,
   output logic                               MICROSEQ_SelectB_Out,
   output logic                               MICROSEQ_SelectC_Out,
   output logic [DATAWIDTH_ALU_SELECTION-1:0] MICROSEQ_ALUOperation_OutBus,
   output logic                               MICROSEQ_RD_Out,
   output logic                               MICROSEQ_WR_Out,
   output logic                               MICROSEQ_RegWrite_Out,
   input  logic                               MICROSEQ_FlagNegative_In,
   input  logic                               MICROSEQ_FlagZero_In,
   input  logic                               MICROSEQ_FlagOverflow_In,
   input  logic                               MICROSEQ_FlagCarry_In,
   input  logic                               MICROSEQ_IR13_In,
   input  logic [DATAWIDTH_DECODEROP-1:0]     MICROSEQ_DecodeOP_InBus,
   input  logic                               MICROSEQ_MemoryAck_In
);

   // MIR bit positions, LSB upward: JUMP, COND, ALU, WR, RD, CMUX, C, BMUX, B, AMUX, A
   localparam int COND_W   = 3;
   localparam int COND_LSB = DATAWIDTH_CS_ADDRESS;
   localparam int ALU_LSB  = COND_LSB + COND_W;
   localparam int WR_BIT   = ALU_LSB + DATAWIDTH_ALU_SELECTION;
   localparam int RD_BIT   = WR_BIT + 1;
   localparam int CMUX_BIT = RD_BIT + 1;
   localparam int C_LSB    = CMUX_BIT + 1;
   localparam int BMUX_BIT = C_LSB + DATAWIDTH_MIR_DIRECTION;
   localparam int B_LSB    = BMUX_BIT + 1;
   localparam int AMUX_BIT = B_LSB + DATAWIDTH_MIR_DIRECTION;
   localparam int A_LSB    = AMUX_BIT + 1;

   localparam logic [DATAWIDTH_CS_ADDRESS-1:0] ADDR_ONE = 1;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEMWAIT
   } state_t;

   state_t                            state;
   logic [DATAWIDTH_CS_ADDRESS-1:0]   csar;
   logic [DATAWIDTH_CS_WORD-1:0]      mir;
   logic                              rd_q;
   logic                              wr_q;

   logic                              mir_rd;
   logic                              mir_wr;
   logic [COND_W-1:0]                 mir_cond;
   logic [DATAWIDTH_CS_ADDRESS-1:0]   mir_jump;
   logic [DATAWIDTH_CS_ADDRESS-1:0]   csar_inc;
   logic [DATAWIDTH_CS_ADDRESS-1:0]   next_addr;
   logic                              complete;

   assign mir_rd   = mir[RD_BIT];
   assign mir_wr   = mir[WR_BIT];
   assign mir_cond = mir[COND_LSB +: COND_W];
   assign mir_jump = mir[0 +: DATAWIDTH_CS_ADDRESS];
   assign csar_inc = csar + ADDR_ONE;

   // A microinstruction completes in EXEC when it needs no memory or the ack
   // is already present, otherwise in MEMWAIT on the ack.
   always_comb begin
      complete = 1'b0;
      case (state)
         ST_EXEC:    complete = !(mir_rd || mir_wr) || MICROSEQ_MemoryAck_In;
         ST_MEMWAIT: complete = MICROSEQ_MemoryAck_In;
         default:    complete = 1'b0;
      endcase
   end

   always_comb begin
      next_addr = csar_inc;
      case (mir_cond)
         3'd0: next_addr = csar_inc;
         3'd1: next_addr = MICROSEQ_FlagNegative_In ? mir_jump : csar_inc;
         3'd2: next_addr = MICROSEQ_FlagZero_In     ? mir_jump : csar_inc;
         3'd3: next_addr = MICROSEQ_FlagOverflow_In ? mir_jump : csar_inc;
         3'd4: next_addr = MICROSEQ_FlagCarry_In    ? mir_jump : csar_inc;
         3'd5: next_addr = MICROSEQ_IR13_In         ? mir_jump : csar_inc;
         3'd6: next_addr = mir_jump;
         // Opcode dispatch table lives in the upper half of the store.
         3'd7: next_addr = {1'b1, MICROSEQ_DecodeOP_InBus, 2'b00};
         default: next_addr = csar_inc;
      endcase
   end

   // Strobes are registered: loaded at the FETCH edge from the incoming word,
   // cleared at the completing edge, so they are low throughout FETCH.
   always_ff @(posedge MICROSEQ_CLOCK_50 or negedge MICROSEQ_ResetInLow_In) begin
      if (!MICROSEQ_ResetInLow_In) begin
         state <= ST_FETCH;
         csar  <= '0;
         mir   <= '0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               mir   <= MICROSEQ_CSWord_InBus;
               rd_q  <= MICROSEQ_CSWord_InBus[RD_BIT];
               wr_q  <= MICROSEQ_CSWord_InBus[WR_BIT] & ~MICROSEQ_CSWord_InBus[RD_BIT];
               state <= ST_EXEC;
            end
            ST_EXEC, ST_MEMWAIT: begin
               if (complete) begin
                  csar  <= next_addr;
                  rd_q  <= 1'b0;
                  wr_q  <= 1'b0;
                  state <= ST_FETCH;
               end else begin
                  state <= ST_MEMWAIT;
               end
            end
            default: begin
               rd_q  <= 1'b0;
               wr_q  <= 1'b0;
               state <= ST_FETCH;
            end
         endcase
      end
   end

   assign MICROSEQ_CSAddress_OutBus    = csar;
   assign MICROSEQ_DirA_OutBus         = mir[A_LSB +: DATAWIDTH_MIR_DIRECTION];
   assign MICROSEQ_SelectA_Out         = mir[AMUX_BIT];
   assign MICROSEQ_DirB_OutBus         = mir[B_LSB +: DATAWIDTH_MIR_DIRECTION];
   assign MICROSEQ_SelectB_Out         = mir[BMUX_BIT];
   assign MICROSEQ_DirC_OutBus         = mir[C_LSB +: DATAWIDTH_MIR_DIRECTION];
   assign MICROSEQ_SelectC_Out         = mir[CMUX_BIT];
   assign MICROSEQ_ALUOperation_OutBus = mir[ALU_LSB +: DATAWIDTH_ALU_SELECTION];
   assign MICROSEQ_RD_Out              = rd_q;
   assign MICROSEQ_WR_Out              = wr_q;
   assign MICROSEQ_RegWrite_Out        = complete;

endmodule
